spi_temp_poller: RTL and testbench

Parametrised SPI master that autonomously polls NUM_CH SPI temperature sensors (LM70/LM07 family, shared SCK/SIO, one active-low CS per sensor) and keeps the latest reading of each. It is the successor to the single-sensor reader in `digital_temp_monitor_top`. It adds configurable frame and data widths, an SCK divider, periodic scans, and per-channel signed over-temperature alarms with hysteresis. It sits between the top-level `uio` pins and the display/alarm logic.

---
 rtl/spi_temp_poller.sv | 205 ++++++++++++++++++++
 tb/tb_spi_temp_poller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_temp_poller.sv
`default_nettype none
// ============================================================================
// Module   : spi_temp_poller
// Purpose  : Autonomous SPI master polling NUM_CH LM70/LM07-style sensors on
//            a shared SCK/SIO bus. Keeps the latest reading of each channel
//            and a per-channel signed over-temperature alarm with hysteresis.
// Revision : 1.0  initial release
// ============================================================================
module spi_temp_poller #(
    parameter int NUM_CH      = 2,
    parameter int FRAME_BITS  = 16,
    parameter int DATA_BITS   = 8,
    parameter int CLK_DIV     = 2,
    parameter int POLL_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          start,
    input  logic [DATA_BITS-1:0]          thresh_hi,
    input  logic [DATA_BITS-1:0]          thresh_lo,
    input  logic                          miso,
    output logic [NUM_CH-1:0]             cs_n,
    output logic                          sck,
    output logic [NUM_CH*DATA_BITS-1:0]   temp_data,
    output logic                          valid,
    output logic [2:0]                    ch_id,
    output logic [NUM_CH-1:0]             alarm,
    output logic                          busy
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_HI    = 3'd2;
    localparam logic [2:0] c_ST_LO    = 3'd3;
    localparam logic [2:0] c_ST_GAP   = 3'd4;
    localparam logic [2:0] c_ST_WAIT  = 3'd5;

    localparam int c_DIV_W  = $clog2(CLK_DIV + 1);
    localparam int c_BIT_W  = $clog2(FRAME_BITS + 1);
    localparam int c_WAIT_W = $clog2(POLL_CYCLES + 1);

    logic [2:0]                  r_state;
    logic [2:0]                  w_state_nxt;
    logic [2:0]                  r_ch_id;
    logic [2:0]                  w_ch_nxt;
    logic [NUM_CH-1:0]           r_cs_n;
    logic [NUM_CH-1:0]           w_cs_n_nxt;
    logic                        r_sck;
    logic                        w_sck_nxt;
    logic                        r_busy;
    logic                        w_busy_nxt;
    logic [c_DIV_W-1:0]          r_div_cnt;
    logic [c_BIT_W-1:0]          r_bit_cnt;
    logic [c_WAIT_W-1:0]         r_wait_cnt;
    logic [FRAME_BITS-1:0]       r_shift;
    logic [FRAME_BITS-1:0]       w_shift_nxt;
    logic [NUM_CH*DATA_BITS-1:0] r_temp;
    logic                        r_valid;
    logic [NUM_CH-1:0]           r_alarm;

    logic                        w_div_done;
    logic                        w_last_bit;
    logic                        w_wait_done;
    logic                        w_last_ch;
    logic                        w_enter_hi;
    logic                        w_enter_gap;
    logic                        w_enter_setup;
    logic [DATA_BITS-1:0]        w_reading;
    logic                        w_set;
    logic                        w_clr;

    assign w_div_done  = (r_div_cnt == c_DIV_W'(CLK_DIV - 1));
    assign w_last_bit  = (r_bit_cnt == c_BIT_W'(FRAME_BITS));
    assign w_wait_done = (r_wait_cnt == c_WAIT_W'(POLL_CYCLES));
    assign w_last_ch   = (r_ch_id == 3'(NUM_CH - 1));

    assign w_enter_hi    = (w_state_nxt == c_ST_HI)    && (r_state != c_ST_HI);
    assign w_enter_gap   = (w_state_nxt == c_ST_GAP)   && (r_state != c_ST_GAP);
    assign w_enter_setup = (w_state_nxt == c_ST_SETUP) && (r_state != c_ST_SETUP);

    // Reading is the top DATA_BITS of the completed frame; compares are signed
    assign w_reading = r_shift[FRAME_BITS-1 -: DATA_BITS];
    assign w_set     = $signed(w_reading) >= $signed(thresh_hi);
    assign w_clr     = $signed(w_reading) <  $signed(thresh_lo);

    // Next-state decode; en is only consulted in IDLE, at GAP exit and in WAIT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (en) w_state_nxt = c_ST_SETUP;
            c_ST_SETUP: if (w_div_done) w_state_nxt = c_ST_HI;
            c_ST_HI:    if (w_div_done) w_state_nxt = c_ST_LO;
            c_ST_LO:    if (w_div_done) w_state_nxt = w_last_bit ? c_ST_GAP : c_ST_HI;
            c_ST_GAP: begin
                if (w_div_done) begin
                    if (!en)            w_state_nxt = c_ST_IDLE;
                    else if (w_last_ch) w_state_nxt = c_ST_WAIT;
                    else                w_state_nxt = c_ST_SETUP;
                end
            end
            c_ST_WAIT: begin
                if (!en)                        w_state_nxt = c_ST_IDLE;
                else if (start || w_wait_done)  w_state_nxt = c_ST_SETUP;
            end
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output decode from the next state so the pins are registered with it
    always_comb begin
        w_ch_nxt = r_ch_id;
        if (w_enter_setup) begin
            w_ch_nxt = (r_state == c_ST_GAP) ? r_ch_id + 3'd1 : 3'd0;
        end
        w_cs_n_nxt = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            if ((w_state_nxt == c_ST_SETUP || w_state_nxt == c_ST_HI ||
                 w_state_nxt == c_ST_LO) && (w_ch_nxt == 3'(k))) begin
                w_cs_n_nxt[k] = 1'b0;
            end
        end
        w_sck_nxt  = (w_state_nxt == c_ST_HI);
        w_busy_nxt = (w_state_nxt == c_ST_SETUP) || (w_state_nxt == c_ST_HI) ||
                     (w_state_nxt == c_ST_LO)    || (w_state_nxt == c_ST_GAP);
    end

    // State register together with the bus-facing control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_ch_id <= 3'd0;
            r_cs_n  <= '1;
            r_sck   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ch_id <= w_ch_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_sck   <= w_sck_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // MSB-first shift: new bit enters at the bottom
    always_comb begin
        w_shift_nxt[0] = miso;
        for (int i = 1; i < FRAME_BITS; i++) begin
            w_shift_nxt[i] = r_shift[i-1];
        end
    end

    // Phase timer, bit counter, poll timer and receive shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_shift    <= '0;
        end else begin
            r_div_cnt  <= (w_state_nxt != r_state) ? '0 : r_div_cnt + c_DIV_W'(1);
            r_wait_cnt <= (r_state != c_ST_WAIT) ? '0 : r_wait_cnt + c_WAIT_W'(1);
            if (w_enter_setup) begin
                r_bit_cnt <= '0;
            end else if (w_enter_hi) begin
                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
            end
            // Sample on the edge that raises sck; sensor shifts on the fall
            if (w_enter_hi) begin
                r_shift <= w_shift_nxt;
            end
        end
    end

    // Commit the finished frame to its channel slice and update its alarm
    always_ff @(posedge clk) begin
        if (rst) begin
            r_temp  <= '0;
            r_valid <= 1'b0;
            r_alarm <= '0;
        end else begin
            r_valid <= w_enter_gap;
            if (w_enter_gap) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (r_ch_id == 3'(k)) begin
                        r_temp[k*DATA_BITS +: DATA_BITS] <= w_reading;
                        // Set wins over clear when the thresholds are inverted
                        if (w_set)      r_alarm[k] <= 1'b1;
                        else if (w_clr) r_alarm[k] <= 1'b0;
                    end
                end
            end
        end
    end

    assign cs_n      = r_cs_n;
    assign sck       = r_sck;
    assign temp_data = r_temp;
    assign valid     = r_valid;
    assign ch_id     = r_ch_id;
    assign alarm     = r_alarm;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_temp_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_temp_poller
// Purpose  : Directed self-checking bench for spi_temp_poller with LM07-style
//            sensor models (default build plus a 3-channel/12-bit build).
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_temp_poller;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    // Default-parameter instance
    logic        en_a, start_a, miso_a, sck_a, valid_a, busy_a;
    logic [7:0]  th_hi_a, th_lo_a;
    logic [1:0]  cs_n_a, alarm_a;
    logic [15:0] temp_a;
    logic [2:0]  ch_a;
    logic [15:0] sv_a [2];

    // Small-frame instance
    logic        en_b, start_b, miso_b, sck_b, valid_b, busy_b;
    logic [9:0]  th_hi_b, th_lo_b;
    logic [2:0]  cs_n_b, alarm_b, ch_b;
    logic [29:0] temp_b;
    logic [15:0] sv_b [3];

    always #5 clk = ~clk;

    spi_temp_poller dut_a (
        .clk(clk), .rst(rst), .en(en_a), .start(start_a),
        .thresh_hi(th_hi_a), .thresh_lo(th_lo_a), .miso(miso_a),
        .cs_n(cs_n_a), .sck(sck_a), .temp_data(temp_a), .valid(valid_a),
        .ch_id(ch_a), .alarm(alarm_a), .busy(busy_a)
    );

    spi_temp_poller #(.NUM_CH(3), .FRAME_BITS(12), .DATA_BITS(10),
                      .CLK_DIV(1), .POLL_CYCLES(20)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .start(start_b),
        .thresh_hi(th_hi_b), .thresh_lo(th_lo_b), .miso(miso_b),
        .cs_n(cs_n_b), .sck(sck_b), .temp_data(temp_b), .valid(valid_b),
        .ch_id(ch_b), .alarm(alarm_b), .busy(busy_b)
    );

    // Sensor models: MSB on CS fall, advance one bit on every SCK fall
    int   bidx_a = 0, bidx_b = 0;
    logic sck_a_prev = 1'b0, sck_b_prev = 1'b0;

    always @(negedge clk) begin
        if (&cs_n_a) bidx_a <= 0;
        else if (sck_a_prev && !sck_a) bidx_a <= bidx_a + 1;
        sck_a_prev <= sck_a;
        if (&cs_n_b) bidx_b <= 0;
        else if (sck_b_prev && !sck_b) bidx_b <= bidx_b + 1;
        sck_b_prev <= sck_b;
    end

    always_comb begin
        miso_a = 1'b0;
        for (int k = 0; k < 2; k++)
            if (!cs_n_a[k] && bidx_a < 16) miso_a = sv_a[k][15 - bidx_a];
        miso_b = 1'b0;
        for (int k = 0; k < 3; k++)
            if (!cs_n_b[k] && bidx_b < 16) miso_b = sv_b[k][15 - bidx_b];
    end

    task automatic wait_cs_a(input int k, input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cs_n_a[k] == lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cs_n_a !== 2'b11) begin errors++; $display("FAIL reset_cs_n: got %b expected 11", cs_n_a); end
        checks++; if (sck_a !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", sck_a); end
        checks++; if (temp_a !== 16'h0) begin errors++; $display("FAIL reset_temp: got %h expected 0000", temp_a); end
        checks++; if ({valid_a, busy_a, ch_a, alarm_a} !== 7'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {valid_a, busy_a, ch_a, alarm_a}); end
        checks++; if (cs_n_b !== 3'b111) begin errors++; $display("FAIL reset_cs_n_b: got %b expected 111", cs_n_b); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cs_n_a !== 2'b11 || busy_a !== 1'b0) begin errors++; $display("FAIL idle_hold: cs_n=%b busy=%b expected 11/0", cs_n_a, busy_a); end
    endtask

    task automatic test_scan();
        int low, nsck, hi;
        logic prev, busy_w;
        sv_a[0] = 16'h3280; sv_a[1] = 16'hE700;
        en_a = 1'b1;
        @(negedge clk);
        checks++; if (cs_n_a !== 2'b10) begin errors++; $display("FAIL first_cs: got %b expected 10", cs_n_a); end
        low = 1; nsck = 0; prev = sck_a;
        for (int i = 0; i < 200 && cs_n_a[0] == 1'b0; i++) begin
            @(negedge clk);
            if (!cs_n_a[0]) begin
                low++;
                if (sck_a && !prev) nsck++;
            end
            prev = sck_a;
        end
        checks++; if (low != 66) begin errors++; $display("FAIL frame_len: got %0d expected 66", low); end
        checks++; if (nsck != 16) begin errors++; $display("FAIL sck_pulses: got %0d expected 16", nsck); end
        checks++; if (valid_a !== 1'b1 || temp_a[7:0] !== 8'h32 || ch_a !== 3'd0) begin errors++; $display("FAIL ch0_read: valid=%b data=%h ch=%0d expected 1/32/0", valid_a, temp_a[7:0], ch_a); end
        checks++; if (alarm_a !== 2'b01) begin errors++; $display("FAIL alarm_set: got %b expected 01", alarm_a); end
        @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b expected 0", valid_a); end
        @(negedge clk);
        checks++; if (cs_n_a !== 2'b01 || ch_a !== 3'd1) begin errors++; $display("FAIL ch1_start: cs_n=%b ch=%0d expected 01/1", cs_n_a, ch_a); end
        for (int i = 0; i < 200 && cs_n_a[1] == 1'b0; i++) @(negedge clk);
        checks++; if (valid_a !== 1'b1 || temp_a !== 16'hE732 || ch_a !== 3'd1) begin errors++; $display("FAIL ch1_read: valid=%b data=%h ch=%0d expected 1/e732/1", valid_a, temp_a, ch_a); end
        checks++; if (alarm_a !== 2'b01) begin errors++; $display("FAIL alarm_neg: got %b expected 01", alarm_a); end
        sv_a[0] = 16'h2C00;
        hi = 1; busy_w = 1'bx;
        for (int i = 0; i < 1100 && cs_n_a == 2'b11; i++) begin
            @(negedge clk);
            if (cs_n_a == 2'b11) hi++;
            if (hi == 10) busy_w = busy_a;
        end
        checks++; if (hi != 1003) begin errors++; $display("FAIL idle_gap: got %0d expected 1003", hi); end
        checks++; if (busy_w !== 1'b0) begin errors++; $display("FAIL wait_busy: got %b expected 0", busy_w); end
        checks++; if (cs_n_a !== 2'b10) begin errors++; $display("FAIL rescan_cs: got %b expected 10", cs_n_a); end
    endtask

    task automatic test_alarm_hold();
        bit ok;
        wait_cs_a(0, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_timeout: got timeout expected frame end"); end
        checks++; if (temp_a[7:0] !== 8'h2C || alarm_a[0] !== 1'b1) begin errors++; $display("FAIL alarm_hold: data=%h alarm=%b expected 2c/1", temp_a[7:0], alarm_a[0]); end
        sv_a[0] = 16'h2700;
    endtask

    task automatic test_start_in_wait();
        bit ok;
        wait_cs_a(1, 1'b0, ok);
        if (ok) wait_cs_a(1, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL start_timeout: got timeout expected ch1 frame"); end
        @(negedge clk);
        repeat (10) @(negedge clk);
        checks++; if (cs_n_a !== 2'b11 || busy_a !== 1'b0) begin errors++; $display("FAIL in_wait: cs_n=%b busy=%b expected 11/0", cs_n_a, busy_a); end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checks++; if (cs_n_a !== 2'b10 || ch_a !== 3'd0 || busy_a !== 1'b1) begin errors++; $display("FAIL start_early: cs_n=%b ch=%0d busy=%b expected 10/0/1", cs_n_a, ch_a, busy_a); end
        wait_cs_a(0, 1'b1, ok);
        checks++; if (temp_a[7:0] !== 8'h27 || alarm_a[0] !== 1'b0) begin errors++; $display("FAIL alarm_clear: data=%h alarm=%b expected 27/0", temp_a[7:0], alarm_a[0]); end
    endtask

    task automatic test_rst_mid();
        bit ok;
        int n;
        logic prev;
        wait_cs_a(1, 1'b0, ok);
        n = 0; prev = sck_a;
        for (int i = 0; i < 200 && ok && n < 8; i++) begin
            @(negedge clk);
            if (sck_a && !prev) n++;
            prev = sck_a;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL rst_setup: got %0d pulses expected 8", n); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (cs_n_a !== 2'b11 || sck_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL rst_bus: cs_n=%b sck=%b busy=%b expected 11/0/0", cs_n_a, sck_a, busy_a); end
        checks++; if (temp_a !== 16'h0 || alarm_a !== 2'b00 || valid_a !== 1'b0) begin errors++; $display("FAIL rst_data: temp=%h alarm=%b valid=%b expected 0000/00/0", temp_a, alarm_a, valid_a); end
        @(negedge clk);
        checks++; if (cs_n_a !== 2'b10 || ch_a !== 3'd0) begin errors++; $display("FAIL rst_restart: cs_n=%b ch=%0d expected 10/0", cs_n_a, ch_a); end
    endtask

    task automatic test_en_drop();
        bit ok;
        int bad;
        repeat (20) @(negedge clk);
        en_a = 1'b0;
        wait_cs_a(0, 1'b1, ok);
        checks++; if (!ok || valid_a !== 1'b1 || ch_a !== 3'd0 || temp_a !== 16'h0027) begin errors++; $display("FAIL en_drop_frame: ok=%b valid=%b ch=%0d temp=%h expected 1/1/0/0027", ok, valid_a, ch_a, temp_a); end
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (cs_n_a !== 2'b11 || valid_a !== 1'b0) bad++;
        end
        checks++; if (bad != 0 || busy_a !== 1'b0) begin errors++; $display("FAIL en_drop_idle: active_cycles=%0d busy=%b expected 0/0", bad, busy_a); end
    endtask

    task automatic test_start_ignored();
        int bad;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (cs_n_a !== 2'b11) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL start_idle: active_cycles=%0d expected 0", bad); end
    endtask

    task automatic test_small_frame();
        int low, nsck, total;
        logic prev;
        logic [9:0] slice0;
        bit ok;
        sv_b[0] = 16'h3280; sv_b[1] = 16'hE700; sv_b[2] = 16'h1234;
        th_hi_b = 10'h0C0; th_lo_b = 10'h100;
        en_b = 1'b1;
        @(negedge clk);
        checks++; if (cs_n_b !== 3'b110) begin errors++; $display("FAIL b_first_cs: got %b expected 110", cs_n_b); end
        low = 1; nsck = 0; total = 1; prev = sck_b; slice0 = 10'h3FF;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!cs_n_b[1]) break;
            total++;
            if (!cs_n_b[0]) begin
                low++;
                if (sck_b && !prev) nsck++;
            end else if (valid_b) begin
                slice0 = temp_b[9:0];
            end
            prev = sck_b;
        end
        checks++; if (total != 26 || low != 25) begin errors++; $display("FAIL b_frame_len: period=%0d low=%0d expected 26/25", total, low); end
        checks++; if (nsck != 12) begin errors++; $display("FAIL b_sck_pulses: got %0d expected 12", nsck); end
        checks++; if (slice0 !== 10'h0CA) begin errors++; $display("FAIL b_ch0_read: got %h expected 0ca", slice0); end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid_b && ch_b == 3'd2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || temp_b !== {10'h048, 10'h39C, 10'h0CA}) begin errors++; $display("FAIL b_scan_data: ok=%b temp=%h expected 1/%h", ok, temp_b, {10'h048, 10'h39C, 10'h0CA}); end
        checks++; if (alarm_b !== 3'b001) begin errors++; $display("FAIL b_alarm_prio: got %b expected 001", alarm_b); end
        en_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en_a = 1'b0; start_a = 1'b0; en_b = 1'b0; start_b = 1'b0;
        th_hi_a = 8'h30; th_lo_a = 8'h28; th_hi_b = 10'h0C0; th_lo_b = 10'h100;
        sv_a[0] = 16'h0; sv_a[1] = 16'h0;
        sv_b[0] = 16'h0; sv_b[1] = 16'h0; sv_b[2] = 16'h0;
        test_reset();
        test_scan();
        test_alarm_hold();
        test_start_in_wait();
        test_rst_mid();
        test_en_drop();
        test_start_ignored();
        test_small_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
